// File: rtl/fft_bin_reader.sv
`default_nettype none
// ============================================================================
// Module : fft_bin_reader
// Brief  : Drains the first half of a completed FFT frame over the DMA read
//          port, streams |re|+|im| bin magnitudes and tracks the frame's peak.
//          Build option FFT_BIN_READER_DC_SKIP_EN excludes bin 0 from the peak.
// Rev    : 1.0  initial release
// ============================================================================
module fft_bin_reader #(
    parameter  int FFT_LENGTH = 1024,
    parameter  int FFT_DW     = 16,
    parameter  int RD_LAT     = 2,
    localparam int FFT_N      = $clog2(FFT_LENGTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_i,
    input  logic [7:0]               bfpexp_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     dmaact_o,
    output logic [FFT_N-1:0]         dmaa_o,
    input  logic signed [FFT_DW-1:0] dmadr_real_i,
    input  logic signed [FFT_DW-1:0] dmadr_imag_i,
    output logic                     bin_valid_o,
    input  logic                     bin_ready_i,
    output logic [FFT_N-2:0]         bin_idx_o,
    output logic [FFT_DW:0]          bin_mag_o,
    output logic                     bin_last_o,
    output logic [7:0]               bfpexp_o,
    output logic                     peak_valid_o,
    output logic [FFT_N-2:0]         peak_idx_o,
    output logic [FFT_DW:0]          peak_mag_o
);

    localparam int c_DEPTH = RD_LAT + 2;
    localparam int c_PW    = $clog2(c_DEPTH);
    localparam int c_CW    = $clog2(c_DEPTH + 1);
    localparam logic [FFT_N-2:0] c_LAST_IDX = {(FFT_N-1){1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [FFT_N-2:0]  r_issue_cnt;
    logic [c_CW-1:0]   r_inflight;
    logic [c_CW-1:0]   r_count;
    logic [c_PW-1:0]   r_wr_ptr;
    logic [c_PW-1:0]   r_rd_ptr;
    logic [RD_LAT-1:0] r_pipe_vld;
    logic [FFT_N-2:0]  r_pipe_idx [RD_LAT];
    logic [FFT_N-2:0]  r_mem_idx  [c_DEPTH];
    logic [FFT_DW:0]   r_mem_mag  [c_DEPTH];
    logic [7:0]        r_bfpexp;
    logic              r_peak_valid;
    logic [FFT_N-2:0]  r_peak_idx;
    logic [FFT_DW:0]   r_peak_mag;

    logic              w_start_acc;
    logic              w_issue;
    logic              w_push;
    logic              w_pop;
    logic              w_peak_ok;
    logic [c_CW:0]     w_used;
    logic [FFT_DW-1:0] w_abs_re;
    logic [FFT_DW-1:0] w_abs_im;
    logic [FFT_DW:0]   w_mag;

    function automatic logic [c_PW-1:0] f_ptr_inc(input logic [c_PW-1:0] p);
        return (p == c_PW'(c_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Every issued read owns a FIFO slot until popped, so the FIFO cannot overflow.
    assign w_used      = (c_CW+1)'(r_inflight) + (c_CW+1)'(r_count);
    assign w_issue     = (r_state == S_READ) && (w_used < (c_CW+1)'(c_DEPTH));
    assign w_start_acc = (r_state == S_IDLE) && start_i;
    assign w_push      = r_pipe_vld[RD_LAT-1];
    assign w_pop       = bin_valid_o && bin_ready_i;

    assign w_abs_re = dmadr_real_i[FFT_DW-1] ? $unsigned(-dmadr_real_i) : $unsigned(dmadr_real_i);
    assign w_abs_im = dmadr_imag_i[FFT_DW-1] ? $unsigned(-dmadr_imag_i) : $unsigned(dmadr_imag_i);
    assign w_mag    = {1'b0, w_abs_re} + {1'b0, w_abs_im};

`ifdef FFT_BIN_READER_DC_SKIP_EN
    assign w_peak_ok = (r_pipe_idx[RD_LAT-1] != '0);
`else
    assign w_peak_ok = 1'b1;
`endif

    assign dmaact_o     = w_issue;
    assign dmaa_o       = {1'b0, r_issue_cnt};
    assign bin_valid_o  = (r_count != '0);
    assign bin_idx_o    = bin_valid_o ? r_mem_idx[r_rd_ptr] : '0;
    assign bin_mag_o    = bin_valid_o ? r_mem_mag[r_rd_ptr] : '0;
    assign bin_last_o   = bin_valid_o && (r_mem_idx[r_rd_ptr] == c_LAST_IDX);
    assign bfpexp_o     = r_bfpexp;
    assign peak_valid_o = r_peak_valid;
    assign peak_idx_o   = r_peak_idx;
    assign peak_mag_o   = r_peak_mag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_state_nxt = S_READ;
                end
            end
            S_READ: begin
                busy_o = 1'b1;
                if (w_issue && (r_issue_cnt == c_LAST_IDX)) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy_o = 1'b1;
                if (w_pop && bin_last_o) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                busy_o      = 1'b1;
                done_o      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Delay line mirrors the DMA read latency so each return knows its bin index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipe_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_pipe_idx[i] <= '0;
            end
        end else begin
            r_pipe_vld[0] <= w_issue;
            r_pipe_idx[0] <= r_issue_cnt;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_idx[i] <= r_pipe_idx[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_idx[r_wr_ptr] <= r_pipe_idx[RD_LAT-1];
            r_mem_mag[r_wr_ptr] <= w_mag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issue_cnt  <= '0;
            r_inflight   <= '0;
            r_count      <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_bfpexp     <= '0;
            r_peak_valid <= 1'b0;
            r_peak_idx   <= '0;
            r_peak_mag   <= '0;
        end else begin
            // Address saturates at the last bin so dmaa_o holds once issue ends.
            if (w_start_acc) begin
                r_issue_cnt <= '0;
            end else if (w_issue && (r_issue_cnt != c_LAST_IDX)) begin
                r_issue_cnt <= r_issue_cnt + 1'b1;
            end

            case ({w_issue, w_push})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push) begin
                r_wr_ptr <= f_ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_ptr_inc(r_rd_ptr);
            end

            if (w_start_acc) begin
                r_bfpexp     <= bfpexp_i;
                r_peak_valid <= 1'b0;
                r_peak_idx   <= '0;
                r_peak_mag   <= '0;
            end else begin
                // Strict compare keeps the lowest index among equal magnitudes.
                if (w_push && w_peak_ok && (w_mag > r_peak_mag)) begin
                    r_peak_mag <= w_mag;
                    r_peak_idx <= r_pipe_idx[RD_LAT-1];
                end
                if (r_state == S_DONE) begin
                    r_peak_valid <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fft_bin_reader.sv
`default_nettype none
// ============================================================================
// Module : tb_fft_bin_reader
// Brief  : Directed bench for fft_bin_reader (16-point frame, RD_LAT=2) with a
//          DMA memory model and a per-cycle stream/peak reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_fft_bin_reader;

    localparam int LEN  = 16;
    localparam int HALF = LEN / 2;
    localparam int LAT  = 2;
    localparam int DEP  = LAT + 2;

    logic               clk;
    logic               rst_n;
    logic               start_i;
    logic [7:0]         bfpexp_i;
    logic               busy_o;
    logic               done_o;
    logic               dmaact_o;
    logic [3:0]         dmaa_o;
    logic signed [15:0] dmadr_real_i;
    logic signed [15:0] dmadr_imag_i;
    logic               bin_valid_o;
    logic               bin_ready_i;
    logic [2:0]         bin_idx_o;
    logic [16:0]        bin_mag_o;
    logic               bin_last_o;
    logic [7:0]         bfpexp_o;
    logic               peak_valid_o;
    logic [2:0]         peak_idx_o;
    logic [16:0]        peak_mag_o;

    fft_bin_reader #(.FFT_LENGTH(LEN), .FFT_DW(16), .RD_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .bfpexp_i(bfpexp_i),
        .busy_o(busy_o), .done_o(done_o), .dmaact_o(dmaact_o), .dmaa_o(dmaa_o),
        .dmadr_real_i(dmadr_real_i), .dmadr_imag_i(dmadr_imag_i),
        .bin_valid_o(bin_valid_o), .bin_ready_i(bin_ready_i), .bin_idx_o(bin_idx_o),
        .bin_mag_o(bin_mag_o), .bin_last_o(bin_last_o), .bfpexp_o(bfpexp_o),
        .peak_valid_o(peak_valid_o), .peak_idx_o(peak_idx_o), .peak_mag_o(peak_mag_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int issued, popped, done_cnt;
    bit last_hs_prev, stalled_prev, bp_mode;
    logic [15:0] bp_pat = 16'b1001_0110_0011_1001;

    logic signed [15:0] mem_re [16];
    logic signed [15:0] mem_im [16];

    // DMA memory: data for an address strobed in cycle a is valid in cycle a+LAT.
    logic [3:0] rd_a [LAT];
    logic [LAT-1:0] rd_v;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_v <= '0;
        end else begin
            rd_v    <= {rd_v[LAT-2:0], dmaact_o};
            rd_a[0] <= dmaa_o;
            for (int i = 1; i < LAT; i++) rd_a[i] <= rd_a[i-1];
        end
    end
    assign dmadr_real_i = rd_v[LAT-1] ? mem_re[rd_a[LAT-1]] : 16'sh7E7E;
    assign dmadr_imag_i = rd_v[LAT-1] ? mem_im[rd_a[LAT-1]] : -16'sh3C3C;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    function automatic int model_mag(input int k);
        int r = mem_re[k];
        int i = mem_im[k];
        return iabs(r) + iabs(i);
    endfunction

    function automatic void model_peak(output int pidx, output int pmag);
        pidx = 0;
        pmag = 0;
        for (int k = 0; k < HALF; k++) begin
`ifdef FFT_BIN_READER_DC_SKIP_EN
            if (k == 0) continue;
`endif
            if (model_mag(k) > pmag) begin
                pmag = model_mag(k);
                pidx = k;
            end
        end
    endfunction

    // Stream monitor: reads in address order within credit, bins in order with model magnitudes.
    always @(negedge clk) begin
        if (rst_n) begin
            if (dmaact_o) begin
                check("dma_addr", dmaa_o, issued);
                check("dma_credit", (issued - popped) < DEP, 1);
                issued++;
            end
            if (stalled_prev) check("stall_valid", bin_valid_o, 1);
            if (bin_valid_o) begin
                check("head_idx", bin_idx_o, popped);
                check("head_mag", bin_mag_o, model_mag(popped));
                check("head_last", bin_last_o, popped == HALF - 1);
            end
            check("done_timing", done_o, last_hs_prev);
            if (done_o) done_cnt++;
            last_hs_prev = 1'b0;
            if (bin_valid_o && bin_ready_i) begin
                popped++;
                last_hs_prev = bin_last_o;
            end
            stalled_prev = bin_valid_o && !bin_ready_i;
        end
    end

    initial begin
        bin_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) begin
                bin_ready_i = bp_pat[0];
                bp_pat      = {bp_pat[0], bp_pat[15:1]};
            end else begin
                bin_ready_i = 1'b1;
            end
        end
    end

    task automatic clear_mem();
        for (int k = 0; k < 16; k++) begin
            mem_re[k] = '0;
            mem_im[k] = '0;
        end
    endtask

    task automatic load_ramp();
        clear_mem();
        for (int k = 0; k < HALF; k++) begin
            mem_re[k] = 16'(k);
            mem_im[k] = -16'(k);
        end
    endtask

    task automatic start_frame(input logic [7:0] e);
        @(posedge clk);
        #1;
        issued       = 0;
        popped       = 0;
        done_cnt     = 0;
        last_hs_prev = 1'b0;
        stalled_prev = 1'b0;
        start_i      = 1'b1;
        bfpexp_i     = e;
        @(posedge clk);
        #1;
        start_i  = 1'b0;
        bfpexp_i = 8'h5A;
    endtask

    task automatic wait_done(input logic [7:0] exp_bfp);
        int n = 0;
        int pidx, pmag;
        do begin
            @(negedge clk);
            n++;
        end while (!done_o && n < 300);
        check("done_seen", done_o, 1);
        model_peak(pidx, pmag);
        @(negedge clk);
        check("busy_after_done", busy_o, 0);
        check("peak_valid", peak_valid_o, 1);
        check("peak_idx", peak_idx_o, pidx);
        check("peak_mag", peak_mag_o, pmag);
        check("bfpexp", bfpexp_o, exp_bfp);
        repeat (4) @(negedge clk);
        check("done_count", done_cnt, 1);
        check("reads_issued", issued, HALF);
        check("bins_popped", popped, HALF);
    endtask

    int lat, n;

    initial begin
        rst_n    = 1'b0;
        start_i  = 1'b0;
        bfpexp_i = 8'h00;
        bp_mode  = 1'b0;
        clear_mem();
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {busy_o, done_o, dmaact_o, dmaa_o, bin_valid_o, bin_idx_o,
              bin_mag_o, bin_last_o, bfpexp_o, peak_valid_o, peak_idx_o, peak_mag_o}, 0);
        rst_n = 1'b1;

        // Basic ramp frame, ready held high
        load_ramp();
        start_frame(8'h02);
        check("busy_in_frame", busy_o, 1);
        lat = 0;
        while (!bin_valid_o && lat < 20) begin
            @(posedge clk);
            lat++;
            #1;
        end
        check("first_latency", lat, LAT + 1);
        wait_done(8'h02);
        check("basic_peak_idx", peak_idx_o, 7);
        check("basic_peak_mag", peak_mag_o, 14);

        // Same frame under backpressure
        bp_mode = 1'b1;
        start_frame(8'hFF);
        wait_done(8'hFF);
        bp_mode = 1'b0;

        // Full-scale negative components and a tie
        clear_mem();
        mem_re[3] = -16'sd32768; mem_im[3] = -16'sd32768;
        mem_re[5] = -16'sd32768; mem_im[5] = -16'sd32768;
        start_frame(8'h04);
        wait_done(8'h04);
        check("tie_peak_idx", peak_idx_o, 3);
        check("tie_peak_mag", peak_mag_o, 65536);

        // DC bin dominance
        clear_mem();
        mem_re[0] = 16'sd600; mem_im[0] = -16'sd400;
        mem_re[2] = 16'sd3;   mem_im[2] = 16'sd7;
        start_frame(8'h01);
        wait_done(8'h01);
`ifdef FFT_BIN_READER_DC_SKIP_EN
        check("dc_peak_idx", peak_idx_o, 2);
        check("dc_peak_mag", peak_mag_o, 10);
`else
        check("dc_peak_idx", peak_idx_o, 0);
        check("dc_peak_mag", peak_mag_o, 1000);
`endif

        // Second start while busy is ignored
        load_ramp();
        start_frame(8'hFD);
        @(posedge clk); #1;
        @(posedge clk); #1;
        start_i  = 1'b1;
        bfpexp_i = 8'h05;
        @(posedge clk); #1;
        start_i  = 1'b0;
        wait_done(8'hFD);

        // Reset in the middle of a frame
        start_frame(8'h07);
        n = 0;
        while (popped < 4 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("abort_point_reached", popped >= 4, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset_outputs", {busy_o, done_o, dmaact_o, dmaa_o, bin_valid_o, bin_idx_o,
              bin_mag_o, bin_last_o, bfpexp_o, peak_valid_o, peak_idx_o, peak_mag_o}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("no_done_after_abort", done_cnt, 0);
        start_frame(8'h03);
        wait_done(8'h03);
        check("post_reset_peak_idx", peak_idx_o, 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fft_bin_reader.md
Name: fft_bin_reader

Overview:
- Drains one completed FFT frame from the R2FFT DMA read port: drives `dmaact`/`dmaa` and consumes `dmadr_real`/`dmadr_imag`.
- Converts the first FFT_LENGTH/2 bins to |re|+|im| magnitudes and emits them on a valid/ready stream toward the fingerprint/peak logic.
- Tracks the frame's peak bin.
- Sits between the FFT core and the spectrogram/hash stage, triggered by the FFT `done` pulse.

Parameters:
- FFT_LENGTH, 1024, FFT frame length, power of 2.
- FFT_DW, 16, FFT data bitwidth (signed real/imag).
- FFT_N, $clog2(FFT_LENGTH), address width; derived, not overridden.
- RD_LAT, 2, cycles from `dmaact_o`/`dmaa_o` asserted to `dmadr_*_i` valid; 1..4.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start_i  in  1  one-cycle pulse: FFT frame ready (FFT `done`)
- bfpexp_i  in  8  signed block-floating-point exponent of the frame, sampled on accepted start
- busy_o  out  1  high from accepted start until done_o
- done_o  out  1  one-cycle pulse after last bin handshake
- dmaact_o  out  1  DMA read strobe
- dmaa_o  out  FFT_N  DMA read address
- dmadr_real_i  in  FFT_DW  signed read data, real
- dmadr_imag_i  in  FFT_DW  signed read data, imag
- bin_valid_o  out  1  magnitude stream valid
- bin_ready_i  in  1  magnitude stream ready
- bin_idx_o  out  FFT_N-1  bin index 0..FFT_LENGTH/2-1
- bin_mag_o  out  FFT_DW+1  unsigned |re|+|im|
- bin_last_o  out  1  high with bin FFT_LENGTH/2-1
- bfpexp_o  out  8  exponent latched for the current/last frame
- peak_valid_o  out  1  peak outputs valid for last completed frame
- peak_idx_o  out  FFT_N-1  index of maximum magnitude
- peak_mag_o  out  FFT_DW+1  maximum magnitude

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values: all outputs 0; FSM in IDLE; FIFO empty; in-flight tracking cleared.
- FSM states:
  - IDLE: start_i=1 → READ. On entry to READ: latch bfpexp_i, clear peak_valid_o, clear peak_mag_o and peak_idx_o, reset issue counter.
  - READ: issue one read per cycle while credits are available. After address FFT_LENGTH/2-1 is issued → DRAIN.
  - DRAIN: wait until all in-flight reads are captured and the last bin handshakes (bin_valid_o & bin_ready_i & bin_last_o) → DONE.
  - DONE: one cycle; done_o=1, peak_valid_o←1, busy_o←0 → IDLE.
- start_i outside IDLE is ignored.
- Read issue: dmaact_o=1 with dmaa_o=issue counter only when (in-flight + FIFO occupancy) < FIFO depth (RD_LAT+2). Otherwise dmaact_o=0 and dmaa_o holds.
- Read data return: a delay line of RD_LAT stages marks returning data. Each returning read is written to the output FIFO with its index; the FIFO never overflows.
- Output stream:
  - bin_valid_o = FIFO not empty.
  - Head data holds stable while bin_valid_o & !bin_ready_i.
  - Pop on valid&ready; simultaneous push and pop at full is legal.
- Magnitude: abs each component into FFT_DW bits unsigned (−2^(FFT_DW−1) → 2^(FFT_DW−1)), then sum into FFT_DW+1 bits. No saturation or truncation.
- Peak: updated at FIFO push. Strict greater-than, so ties keep the lower index. Initial peak_mag is 0, index 0.
- Latency: with bin_ready_i held high, first bin_valid_o occurs RD_LAT+1 cycles after start_i. Throughput is then 1 bin/cycle.
- Reset mid-frame: immediate return to IDLE. In-flight reads are discarded, FIFO flushed, no done_o.

Optional Feature:
- Macro: FFT_BIN_READER_DC_SKIP_EN.
- Defined: bin 0 is streamed normally but excluded from the peak search; the peak is taken over bins 1..FFT_LENGTH/2-1.
- Undefined: all streamed bins, including bin 0, participate in the peak search.

Test Plan:
- Basic frame: FFT_LENGTH=16, RD_LAT=2, memory model re=k, im=−k at address k, ready high, start pulse.
  - Reads at addresses 0..7.
  - bins 0..7 with mag=2k; bin_last_o with idx 7.
  - done_o one cycle after that handshake; peak_idx=7, peak_mag=14.
- Backpressure: same frame, bin_ready_i toggled 1-0-0-1 pseudo-randomly.
  - All 8 bins arrive in order, data stable while stalled.
  - dmaact_o never issued when credits = 0; no loss or duplication.
- Extremes and ties: re=−32768, im=−32768 at bin 3, and the same values at bin 5; all others 0.
  - mag=65536 at both bins; peak_idx=3.
- DC skip: bin 0 mag=1000, bin 2 mag=10.
  - Macro defined → peak_idx=2, peak_mag=10.
  - Macro undefined → peak_idx=0, peak_mag=1000.
- Start while busy: second start_i at cycle 3.
  - Ignored; exactly one done_o; bfpexp_o equals the first frame's exponent (e.g. −3).
- Reset mid-frame: rst_n low after 4 bins.
  - All outputs 0 immediately; no done_o.
  - A new start then completes a full 8-bin frame correctly.
